lot_occupancy: RTL and testbench

Consumer side of the front-panel key interface: takes the one-cycle `cen` (car entered) and `cex` (car exited) pulses and maintains the parking-lot occupancy count. It provides full/empty status, sticky over/underflow error flags, and a timed gate-open strobe for each accepted entry. It sits directly downstream of the key-pulse conditioning logic and feeds the lot's LEDs and HEX displays.

---
 rtl/lot_occupancy.sv | 147 ++++++++++++++
 tb/tb_lot_occupancy.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lot_occupancy.sv
// Parking-lot occupancy counter with full/empty, sticky errors and gate strobe.
// Optional LOT_OCCUPANCY_HEX_EN adds registered two-digit 7-segment outputs.
module lot_occupancy #(
  parameter int CAPACITY    = 25,
  parameter int CNT_W       = 7,
  parameter int GATE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             cen,
  input  logic             cex,
  input  logic             clr_err,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             err_over,
  output logic             err_under
`ifdef LOT_OCCUPANCY_HEX_EN
  ,
  output logic [6:0]       hex1,
  output logic [6:0]       hex0
`endif
);

  typedef enum logic {IDLE, OPEN} gate_st_e;

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [7:0]       GC  = 8'(GATE_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;
  logic             eo_q, eo_d;
  logic             eu_q, eu_d;
  gate_st_e         st_q, st_d;
  logic [7:0]       tmr_q, tmr_d;

  logic inc, dec, set_o, set_u, accept;

  assign full  = (count_q == CAP);
  assign empty = (count_q == '0);

  // A swap is accepted even at full or empty.
  assign accept = cen & (cex | ~full);
  assign inc    = cen & ~cex & ~full;
  assign dec    = cex & ~cen & ~empty;
  assign set_o  = cen & ~cex & full;
  assign set_u  = cex & ~cen & empty;

  always_comb begin
    count_d = count_q;
    if (inc)      count_d = count_q + CNT_W'(1);
    else if (dec) count_d = count_q - CNT_W'(1);
  end

  assign eo_d = set_o | (eo_q & ~clr_err);
  assign eu_d = set_u | (eu_q & ~clr_err);

  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    unique case (st_q)
      IDLE: begin
        if (accept) begin
          st_d  = OPEN;
          tmr_d = GC;
        end
      end
      OPEN: begin
        if (accept) begin
          tmr_d = GC;
        end else if (tmr_q <= 8'd1) begin
          st_d  = IDLE;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: begin
        st_d  = IDLE;
        tmr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
      eo_q    <= 1'b0;
      eu_q    <= 1'b0;
      st_q    <= IDLE;
      tmr_q   <= '0;
    end else begin
      count_q <= count_d;
      eo_q    <= eo_d;
      eu_q    <= eu_d;
      st_q    <= st_d;
      tmr_q   <= tmr_d;
    end
  end

  assign count     = count_q;
  assign err_over  = eo_q;
  assign err_under = eu_q;
  assign gate_open = (st_q == OPEN);

`ifdef LOT_OCCUPANCY_HEX_EN
  // Active-low segments, bit order {g,f,e,d,c,b,a}; anything >9 is blank.
  function automatic logic [6:0] seg7(input logic [6:0] d);
    unique case (d)
      7'd0:    seg7 = 7'h40;
      7'd1:    seg7 = 7'h79;
      7'd2:    seg7 = 7'h24;
      7'd3:    seg7 = 7'h30;
      7'd4:    seg7 = 7'h19;
      7'd5:    seg7 = 7'h12;
      7'd6:    seg7 = 7'h02;
      7'd7:    seg7 = 7'h78;
      7'd8:    seg7 = 7'h00;
      7'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7f;
    endcase
  endfunction

  logic [6:0] cnt7, tens, ones;
  logic [6:0] hex1_q, hex0_q, hex1_d, hex0_d;

  assign cnt7   = 7'(count_q);
  assign tens   = cnt7 / 7'd10;
  assign ones   = cnt7 % 7'd10;
  assign hex1_d = (tens == 7'd0) ? 7'h7f : seg7(tens);
  assign hex0_d = seg7(ones);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      hex1_q <= 7'h7f;
      hex0_q <= 7'h40;
    end else begin
      hex1_q <= hex1_d;
      hex0_q <= hex0_d;
    end
  end

  assign hex1 = hex1_q;
  assign hex0 = hex0_q;
`endif

endmodule

// File: tb/tb_lot_occupancy.sv
// Scoreboard bench for lot_occupancy (CAPACITY=3, GATE_CYCLES=2).
// Expected state is queued when stimulus is driven and popped after the edge.
module tb_lot_occupancy;

  localparam int CAP = 3;
  localparam int GC  = 2;
  localparam int W   = 7;

  logic         clk = 1'b0;
  logic         Reset = 1'b0;
  logic         cen = 1'b0, cex = 1'b0, clr_err = 1'b0;
  logic [W-1:0] count;
  logic         full, empty, gate_open, err_over, err_under;
`ifdef LOT_OCCUPANCY_HEX_EN
  logic [6:0]   hex1, hex0;
`endif

  lot_occupancy #(.CAPACITY(CAP), .CNT_W(W), .GATE_CYCLES(GC)) dut (
    .clk(clk), .Reset(Reset), .cen(cen), .cex(cex), .clr_err(clr_err),
    .count(count), .full(full), .empty(empty), .gate_open(gate_open),
    .err_over(err_over), .err_under(err_under)
`ifdef LOT_OCCUPANCY_HEX_EN
    , .hex1(hex1), .hex0(hex0)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cnt;
    logic full, empty, gate, eo, eu;
    int   shown;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  int   m_cnt, m_rem, m_prev;
  logic m_eo, m_eu;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_rem = 0; m_prev = 0;
    m_eo = 1'b0; m_eu = 1'b0;
  endtask

  task automatic compare(input string tag, input exp_t e);
    chk({tag, ".count"}, 32'(count), 32'(e.cnt));
    chk({tag, ".full"}, 32'(full), 32'(e.full));
    chk({tag, ".empty"}, 32'(empty), 32'(e.empty));
    chk({tag, ".gate"}, 32'(gate_open), 32'(e.gate));
    chk({tag, ".eover"}, 32'(err_over), 32'(e.eo));
    chk({tag, ".eunder"}, 32'(err_under), 32'(e.eu));
`ifdef LOT_OCCUPANCY_HEX_EN
    chk({tag, ".hex0"}, 32'(hex0), 32'(seg(e.shown % 10)));
    chk({tag, ".hex1"}, 32'(hex1),
        32'((e.shown < 10) ? 7'b1111111 : seg(e.shown / 10)));
`endif
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input string tag, input logic ce, input logic cx,
                      input logic cl);
    bit   acc;
    exp_t e;
    cen = ce; cex = cx; clr_err = cl;
    acc = 0;
    m_prev = m_cnt;
    if (cl) begin m_eo = 1'b0; m_eu = 1'b0; end
    if (ce && cx) acc = 1;
    else if (ce) begin
      if (m_cnt < CAP) begin m_cnt++; acc = 1; end
      else m_eo = 1'b1;
    end else if (cx) begin
      if (m_cnt > 0) m_cnt--;
      else m_eu = 1'b1;
    end
    if (acc) m_rem = GC;
    else if (m_rem > 0) m_rem--;
    e.cnt = m_cnt; e.full = (m_cnt == CAP); e.empty = (m_cnt == 0);
    e.gate = (m_rem > 0); e.eo = m_eo; e.eu = m_eu; e.shown = m_prev;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      compare(tag, q.pop_front());
    end
    cen = 1'b0; cex = 1'b0; clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_chk(input string tag);
    exp_t e;
    e.cnt = 0; e.full = 0; e.empty = 1; e.gate = 0;
    e.eo = 0; e.eu = 0; e.shown = 0;
    compare(tag, e);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_chk("rst_hold");
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step("enter", 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    step("swap_full", 1'b1, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) step("exit", 1'b0, 1'b1, 1'b0);
    step("under", 1'b0, 1'b1, 1'b0);
    step("under_clr", 1'b0, 1'b1, 1'b1);
    step("clr", 1'b0, 1'b0, 1'b1);
    step("swap_empty", 1'b1, 1'b1, 1'b0);
    idle(3);
    step("retrig0", 1'b1, 1'b0, 1'b0);
    step("retrig1", 1'b1, 1'b0, 1'b0);
    idle(3);
    step("pre_rst", 1'b1, 1'b0, 1'b0);
    step("pre_rst2", 1'b0, 1'b0, 1'b1);
    #2 Reset = 1'b0;
    #1 reset_chk("rst_mid");
    model_reset();
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 1'b1, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 60; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0));
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
